// File: rtl/store_pkg.sv
// Shared encodings, FSM state type and size decode for the store read-modify-write unit.
package store_pkg;

    localparam logic [2:0] ST_B = 3'b000;
    localparam logic [2:0] ST_H = 3'b001;
    localparam logic [2:0] ST_W = 3'b010;
    localparam logic [2:0] ST_D = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrite
    } st_state_e;

    // Access size in bytes; 0 marks an encoding with no defined size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            ST_B:    size_bytes = 4'd1;
            ST_H:    size_bytes = 4'd2;
            ST_W:    size_bytes = 4'd4;
            ST_D:    size_bytes = 4'd8;
            default: size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane insert: replaces bytes [off, off+size) of the old word with the
// low bytes of the new data.
module store_lane_merge #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_old,
    input  logic [XLEN-1:0]  i_new,
    input  logic [OFF_W-1:0] i_off,
    input  logic [3:0]       i_size,
    output logic [XLEN-1:0]  o_merged
);

    localparam int NB = int'(XLEN / 8);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_new << {i_off, 3'b000};

    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < NB; b++) begin
            if (b >= int'(i_off) && b < int'(i_off) + int'(i_size)) begin
                o_merged[8*b +: 8] = w_shifted[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Ex/Mem store unit: aligns and merges sub-word stores via read-modify-write, writes full words
// directly. Optional macro STORE_FWD_EN forwards the last written word to skip the memory read.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [2:0]        req_funct3,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [XLEN-1:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [XLEN-1:0]   mem_wr_data,
    output logic              done,
    output logic              misalign
);

    st_state_e         r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]   r_data, r_wr_data;
    logic [OFF_W-1:0]  r_off;
    logic [3:0]        r_size;
    logic              r_rd_req, r_wr_en, r_done, r_misalign;

    logic [OFF_W-1:0]  w_off;
    logic [ADDR_W-1:0] w_waddr;
    logic [3:0]        w_size;
    logic              w_illegal, w_misal, w_full;
    logic              w_accept, w_reject, w_go, w_fwd_hit;
    logic [XLEN-1:0]   w_mrg_old, w_mrg_new, w_merged;
    logic [OFF_W-1:0]  w_mrg_off;
    logic [3:0]        w_mrg_size;

    assign w_off     = req_addr[OFF_W-1:0];
    assign w_waddr   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_size    = size_bytes(req_funct3);
    assign w_illegal = req_funct3[2] || (req_funct3 == ST_D && XLEN != 64);
    assign w_misal   = (4'(w_off) & (w_size - 4'd1)) != 4'd0;
    assign w_full    = 32'(w_size) == XLEN / 8;

    assign w_accept  = req_valid && (r_state_q == StIdle);
    assign w_reject  = w_accept && (w_illegal || w_misal);
    assign w_go      = w_accept && !w_illegal && !w_misal;

`ifdef STORE_FWD_EN
    logic [ADDR_W-1:0] r_last_addr;
    logic [XLEN-1:0]   r_last_data;
    logic              r_last_vld;

    assign w_fwd_hit  = w_go && !w_full && r_last_vld && (w_waddr == r_last_addr);
    assign w_mrg_old  = w_fwd_hit ? r_last_data : mem_rd_data;
    assign w_mrg_new  = w_fwd_hit ? req_data    : r_data;
    assign w_mrg_off  = w_fwd_hit ? w_off       : r_off;
    assign w_mrg_size = w_fwd_hit ? w_size      : r_size;

    // Snapshot each word as it is written so a following store to it can skip the read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_addr <= '0;
            r_last_data <= '0;
            r_last_vld  <= 1'b0;
        end else if (r_state_q == StWrite) begin
            r_last_addr <= r_waddr;
            r_last_data <= r_wr_data;
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_mrg_old  = mem_rd_data;
    assign w_mrg_new  = r_data;
    assign w_mrg_off  = r_off;
    assign w_mrg_size = r_size;
`endif

    store_lane_merge #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_merge (
        .i_old    (w_mrg_old),
        .i_new    (w_mrg_new),
        .i_off    (w_mrg_off),
        .i_size   (w_mrg_size),
        .o_merged (w_merged)
    );

    always_comb begin
        w_state_d = r_state_q;
        unique case (r_state_q)
            StIdle: begin
                if (w_go) w_state_d = (w_full || w_fwd_hit) ? StWrite : StRdReq;
            end
            StRdReq:  w_state_d = StRdWait;
            StRdWait: if (mem_rd_valid) w_state_d = StWrite;
            StWrite:  w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they coincide with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q  <= StIdle;
            r_rd_req   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_waddr    <= '0;
            r_data     <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_rd_req   <= (w_state_d == StRdReq);
            r_wr_en    <= (w_state_d == StWrite);
            r_done     <= (w_state_d == StWrite) || w_reject;
            r_misalign <= w_reject;
            if (w_go) begin
                r_waddr <= w_waddr;
                r_data  <= req_data;
                r_off   <= w_off;
                r_size  <= w_size;
            end
            if (w_go && w_full) begin
                r_wr_data <= req_data;
            end else if (w_fwd_hit || (r_state_q == StRdWait && mem_rd_valid)) begin
                r_wr_data <= w_merged;
            end
        end
    end

    assign req_ready   = (r_state_q == StIdle);
    assign mem_rd_req  = r_rd_req;
    assign mem_rd_addr = r_waddr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_waddr;
    assign mem_wr_data = r_wr_data;
    assign done        = r_done;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit: a 32-bit and a 64-bit instance share stimulus, selected by sel.
module tb_store_rmw_unit;

`ifdef STORE_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [2:0]  req_funct3;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_data;

    logic        a_ready, a_rd_req, a_wr_en, a_done, a_mis;
    logic [31:0] a_rd_addr, a_wr_addr, a_wr_data;
    logic        b_ready, b_rd_req, b_wr_en, b_done, b_mis;
    logic [31:0] b_rd_addr, b_wr_addr;
    logic [63:0] b_wr_data;

    logic        t_ready, t_rd_req, t_wr_en, t_done, t_mis;
    logic [31:0] t_rd_addr, t_wr_addr;
    logic [63:0] t_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_rmw_unit #(.XLEN(32), .ADDR_W(32)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid && !sel),
        .req_ready    (a_ready),
        .req_addr     (req_addr),
        .req_data     (req_data[31:0]),
        .req_funct3   (req_funct3),
        .mem_rd_req   (a_rd_req),
        .mem_rd_addr  (a_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data[31:0]),
        .mem_wr_en    (a_wr_en),
        .mem_wr_addr  (a_wr_addr),
        .mem_wr_data  (a_wr_data),
        .done         (a_done),
        .misalign     (a_mis)
    );

    store_rmw_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid && sel),
        .req_ready    (b_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_funct3   (req_funct3),
        .mem_rd_req   (b_rd_req),
        .mem_rd_addr  (b_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (b_wr_en),
        .mem_wr_addr  (b_wr_addr),
        .mem_wr_data  (b_wr_data),
        .done         (b_done),
        .misalign     (b_mis)
    );

    assign t_ready   = sel ? b_ready   : a_ready;
    assign t_rd_req  = sel ? b_rd_req  : a_rd_req;
    assign t_wr_en   = sel ? b_wr_en   : a_wr_en;
    assign t_done    = sel ? b_done    : a_done;
    assign t_mis     = sel ? b_mis     : a_mis;
    assign t_rd_addr = sel ? b_rd_addr : a_rd_addr;
    assign t_wr_addr = sel ? b_wr_addr : a_wr_addr;
    assign t_wr_data = sel ? b_wr_data : {32'd0, a_wr_data};

    typedef struct {
        string       name;
        bit          sel;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] data;
        logic [63:0] rdat;
        bit          mis;
        bit          rd;
        logic [31:0] waddr;
        logic [63:0] wdata;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat = 0;
        int          n_rd = 0;
        int          n_wr = 0;
        bit          got = 1'b0;
        logic        mis = 1'b0;
        logic [31:0] wa = '0;
        logic [31:0] ra = '0;
        logic [63:0] wd = '0;
        sel = v.sel;
        req_addr = v.addr;
        req_data = v.data;
        req_funct3 = v.f3;
        mem_rd_data = v.rdat;
        req_valid = 1'b1;
        check({v.name, " ready"}, 64'(t_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (t_rd_req) begin
                n_rd++;
                ra = t_rd_addr;
                mem_rd_valid = 1'b1;
            end
            if (t_wr_en) n_wr++;
            if (t_done) begin
                got = 1'b1;
                lat = c;
                mis = t_mis;
                wa  = t_wr_addr;
                wd  = t_wr_data;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        mem_rd_valid = 1'b0;
        check({v.name, " done"}, 64'(got), 64'd1);
        check({v.name, " misalign"}, 64'(mis), 64'(v.mis));
        check({v.name, " rd_req count"}, 64'(n_rd), 64'(v.rd));
        check({v.name, " wr_en count"}, 64'(n_wr), 64'(!v.mis));
        check({v.name, " latency"}, 64'(lat), 64'(v.lat));
        if (v.rd) check({v.name, " rd_addr"}, 64'(ra), 64'(v.waddr));
        if (!v.mis) begin
            check({v.name, " wr_addr"}, 64'(wa), 64'(v.waddr));
            check({v.name, " wr_data"}, wd, v.wdata);
        end
        @(posedge clk);
        #1;
        check({v.name, " done one cycle"}, 64'(t_done), 64'd0);
        check({v.name, " ready after"}, 64'(t_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int early;
        reset_n = 1'b0;
        sel = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_funct3 = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;

        // name, sel, f3, addr, data, rdat, mis, rd, waddr, wdata, lat
        vecs.push_back('{"sb_103", 1'b0, 3'b000, 32'h103, 64'hAB, 64'h11223344,
                         1'b0, 1'b1, 32'h100, 64'hAB223344, 3});
        vecs.push_back('{"sw_300", 1'b0, 3'b010, 32'h300, 64'hCAFEF00D, 64'h0,
                         1'b0, 1'b0, 32'h300, 64'hCAFEF00D, 1});
        vecs.push_back('{"sh_101_mis", 1'b0, 3'b001, 32'h101, 64'h1234, 64'h0,
                         1'b1, 1'b0, 32'h0, 64'h0, 1});
        vecs.push_back('{"sw_102_mis", 1'b0, 3'b010, 32'h102, 64'h1234, 64'h0,
                         1'b1, 1'b0, 32'h0, 64'h0, 1});
        vecs.push_back('{"sd_x32_ill", 1'b0, 3'b011, 32'h400, 64'h1234, 64'h0,
                         1'b1, 1'b0, 32'h0, 64'h0, 1});
        vecs.push_back('{"f3_100_ill", 1'b0, 3'b100, 32'h000, 64'h1234, 64'h0,
                         1'b1, 1'b0, 32'h0, 64'h0, 1});
        vecs.push_back('{"sb_200_low", 1'b0, 3'b000, 32'h200, 64'h12345699, 64'hAABBCCDD,
                         1'b0, 1'b1, 32'h200, 64'hAABBCC99, 3});
        vecs.push_back('{"sh_000", 1'b0, 3'b001, 32'h000, 64'h1234BEEF, 64'h0,
                         1'b0, 1'b1, 32'h000, 64'h0000BEEF, 3});
        vecs.push_back('{"sb_101", 1'b0, 3'b000, 32'h101, 64'h77, 64'hFFFFFFFF,
                         1'b0, 1'b1, 32'h100, 64'hFFFF77FF, 3});
        vecs.push_back('{"sh_1002", 1'b0, 3'b001, 32'h1002, 64'hFFFF5566, 64'hDEADBEEF,
                         1'b0, 1'b1, 32'h1000, 64'h5566BEEF, 3});
        vecs.push_back('{"sb_302", 1'b0, 3'b000, 32'h302, 64'h5A, 64'h01020304,
                         1'b0, 1'b1, 32'h300, 64'h015A0304, 3});
        vecs.push_back('{"sb_600", 1'b0, 3'b000, 32'h600, 64'h11, 64'hA0B0C0D0,
                         1'b0, 1'b1, 32'h600, 64'hA0B0C011, 3});
        vecs.push_back('{"sb_601_fwd", 1'b0, 3'b000, 32'h601, 64'h22, 64'hA0B0C011,
                         1'b0, !Fwd, 32'h600, 64'hA0B02211, Fwd ? 1 : 3});
        vecs.push_back('{"x64_sw_1004", 1'b1, 3'b010, 32'h1004, 64'h12345678,
                         64'h0011223344556677, 1'b0, 1'b1, 32'h1000, 64'h1234567844556677, 3});
        vecs.push_back('{"x64_sd_2000", 1'b1, 3'b011, 32'h2000, 64'h0123456789ABCDEF, 64'h0,
                         1'b0, 1'b0, 32'h2000, 64'h0123456789ABCDEF, 1});
        vecs.push_back('{"x64_sd_mis", 1'b1, 3'b011, 32'h2004, 64'h1, 64'h0,
                         1'b1, 1'b0, 32'h0, 64'h0, 1});
        vecs.push_back('{"x64_sh_4006", 1'b1, 3'b001, 32'h4006, 64'hBEEF, 64'h1111111111111111,
                         1'b0, 1'b1, 32'h4000, 64'hBEEF111111111111, 3});
        vecs.push_back('{"x64_sb_3007", 1'b1, 3'b000, 32'h3007, 64'hC3, 64'h0,
                         1'b0, 1'b1, 32'h3000, 64'hC300000000000000, 3});

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("reset ready", 64'(a_ready), 64'd1);
        check("reset strobes", {60'd0, a_rd_req, a_wr_en, a_done, a_mis}, 64'd0);
        check("reset wr_data", 64'(a_wr_data), 64'd0);
        check("reset addrs", {a_rd_addr, a_wr_addr}, 64'd0);
        check("reset ready x64", 64'(b_ready), 64'd1);
        check("reset wr_data x64", b_wr_data, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // rd_valid while idle must be ignored
        sel = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data = 64'h55555555;
        @(posedge clk);
        #1 mem_rd_valid = 1'b0;
        check("idle rd_valid ignored", {61'd0, a_wr_en, a_done, a_rd_req}, 64'd0);

        // SH with 5-cycle memory delay: done 6 cycles after rd_req
        req_addr = 32'h202;
        req_data = 64'hFFFF5566;
        req_funct3 = 3'b001;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("delay rd_req", 64'(a_rd_req), 64'd1);
        check("delay rd_addr", 64'(a_rd_addr), 64'h200);
        early = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (a_done || a_wr_en || a_rd_req) early++;
        end
        check("delay no early strobes", 64'(early), 64'd0);
        mem_rd_valid = 1'b1;
        mem_rd_data = 64'hDEADBEEF;
        @(posedge clk);
        #1 mem_rd_valid = 1'b0;
        check("delay done", {62'd0, a_done, a_wr_en}, 64'd3);
        check("delay wr_data", 64'(a_wr_data), 64'h5566BEEF);
        check("delay wr_addr", 64'(a_wr_addr), 64'h200);
        @(posedge clk);
        #1;

        // reset while waiting for read data aborts the store
        req_addr = 32'h500;
        req_data = 64'h33;
        req_funct3 = 3'b000;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        check("abort ready", 64'(a_ready), 64'd1);
        check("abort wr_data cleared", 64'(a_wr_data), 64'd0);
        early = 0;
        mem_rd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 mem_rd_valid = 1'b0;
            if (a_done || a_wr_en || a_rd_req) early++;
        end
        check("abort no write", 64'(early), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
Parametrised sequential store unit for the Ex/Mem stage. It accepts a store request, performs read-modify-write for sub-word stores (SB/SH, and SW when XLEN=64), and writes full-width stores directly. It checks alignment, inserts the data into the correct byte lanes, and sequences the data-memory read and write ports through a small FSM with a valid/ready front end.

Parameters:
XLEN, 32, data/word width; only 32 or 64 are legal.
ADDR_W, 32, byte-address width.
OFF_W, $clog2(XLEN/8), byte-offset bits (derived; do not override).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  store request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_addr  in  ADDR_W  byte address
req_data  in  XLEN  store data, right-justified
req_funct3  in  3  000 SB, 001 SH, 010 SW, 011 SD (SD legal only when XLEN=64)
mem_rd_req  out  1  one-cycle read strobe
mem_rd_addr  out  ADDR_W  word-aligned read address
mem_rd_valid  in  1  read data valid
mem_rd_data  in  XLEN  read data
mem_wr_en  out  1  one-cycle write strobe
mem_wr_addr  out  ADDR_W  word-aligned write address
mem_wr_data  out  XLEN  merged write word
done  out  1  one-cycle pulse when the request retires (written or rejected)
misalign  out  1  one-cycle pulse together with done when a request is rejected

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE. All strobes (mem_rd_req, mem_wr_en, done, misalign) go to 0. mem_*_addr and mem_wr_data go to 0. req_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the operation: no write is issued, and no done pulse is produced.
- Accept: a request is accepted when req_valid && req_ready at a clk edge. On accept, addr, data, funct3 and offset=addr[OFF_W-1:0] are registered. The word address is addr with its low OFF_W bits cleared.
- Size: 000=1B, 001=2B, 010=4B, 011=8B.
- Full width: size==XLEN/8. Any other legal size is sub-word.
- funct3 011 with XLEN=32, or funct3 1xx, is illegal and is treated as misaligned.
- Alignment: an access is legal when offset is a multiple of its size.
- FSM states: IDLE, RD_REQ, RD_WAIT, WRITE.
- Transitions from IDLE on accept:
  - Illegal or misaligned: stay in IDLE. Next cycle, done=1 and misalign=1. No memory access.
  - Full width: go to WRITE. mem_wr_data = req_data.
  - Sub-word: go to RD_REQ.
- RD_REQ: mem_rd_req=1 for exactly one cycle, with mem_rd_addr = word address. Then go to RD_WAIT.
- RD_WAIT: wait an unbounded number of cycles. On mem_rd_valid, register merged data and go to WRITE. mem_rd_valid outside RD_WAIT is ignored.
- WRITE: mem_wr_en=1 and done=1 for one cycle, with mem_wr_addr = word address. Then go to IDLE.
- Merge rule: bytes [offset, offset+size) of mem_rd_data are replaced by req_data[8*size-1:0], placed at bit 8*offset. All other bytes pass through unchanged. The source is always the low bytes of req_data, for every offset.
- Latency:
  - Full width: accept at T, write and done at T+1.
  - Sub-word: rd_req at T+1; if rd_valid arrives at cycle R, write and done at R+1. Minimum is T+3.
  - Misaligned: done at T+1.
- Back-to-back: req_ready rises in the cycle after done; in that cycle it is combinational from state==IDLE. Throughput is at most one store per 2 cycles for full width and per 4 cycles for sub-word.

Optional Feature:
STORE_FWD_EN
- Defined:
  - Registers last_addr, last_data and last_vld after every WRITE.
  - A sub-word request whose word address equals last_addr while last_vld=1 skips RD_REQ/RD_WAIT. It merges into last_data and goes straight to WRITE (done at T+1, no mem_rd_req).
  - last_vld is cleared on reset.
- Undefined: no forwarding storage exists, and every sub-word store reads memory.

Decomposition:
- Package store_pkg holds:
  - funct3 encodings: ST_B, ST_H, ST_W, ST_D.
  - state enum: st_state_e.
  - function size_bytes(funct3).
- Sub-module store_lane_merge: combinational, parametrised by XLEN. Inputs are old word, new data, offset and size; output is the merged word. It is instantiated once.

Test Plan:
- Reset: reset_n=0 for 2 cycles -> req_ready=1, all strobes 0, mem_wr_data=0.
- XLEN=32 SB, addr 0x103, data 0x000000AB, memory returns 0x11223344 -> mem_wr_addr=0x100, mem_wr_data=0xAB223344, done once.
- XLEN=32 SH, addr 0x202, data 0xFFFF5566, memory 0xDEADBEEF after 5-cycle delay -> wr_data=0x5566BEEF, done 6 cycles after rd_req.
- XLEN=32 SW, addr 0x300, data 0xCAFEF00D -> no rd_req, wr_en at T+1 with 0xCAFEF00D.
- Misaligned: SH at 0x101; SW at 0x102 (XLEN=32); funct3=011 at XLEN=32 -> done=misalign=1 at T+1, no mem strobes.
- XLEN=64 SW at 0x...04, data 0x12345678, memory 0x0011223344556677 -> 0x1234567844556677. Reset asserted in RD_WAIT -> no wr_en, IDLE next cycle. With STORE_FWD_EN: two SB to the same word -> second issues no rd_req.
